// File: rtl/div_32bit_seq_pkg.sv
// Shared types and constants for the sequential MiniMIPS divider.
package div_pkg;

  // Number of quotient bits produced, one per ITER cycle.
  localparam int ITER_COUNT = 32;

  // Quotient returned when the divisor is zero.
  localparam logic [31:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    ITER,
    FIX,
    DONE
  } div_state_t;

endpackage

// File: rtl/div_32bit_seq_if.sv
// Request/response bundle between the control unit and the divider.
interface div_32bit_seq_if #(
  parameter int WIDTH = 32
) ();

  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  // Control unit side: issues requests, consumes results.
  modport master (
    output start, is_signed, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  // Divider side.
  modport slave (
    input  start, is_signed, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/div_32bit_seq_step.sv
// One restoring-division iteration: shift in the next dividend bit,
// trial-subtract the divisor and keep the difference only if it is
// non-negative (same subtract-and-sign-test as the ALU's SLT path).
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH:0]        shifted;
  logic signed [WIDTH:0] trial;

  // The partial remainder stays below 2*divisor, so the difference
  // always fits in WIDTH+1 signed bits and its MSB is a valid sign.
  assign shifted = {rem, q[WIDTH-1]};
  assign trial   = $signed(shifted - {1'b0, divisor});

  // Keep the difference when non-negative, otherwise restore.
  always_comb begin
    if (!trial[WIDTH]) begin
      rem_next = trial[WIDTH-1:0];
      q_next   = {q[WIDTH-2:0], 1'b1};
    end else begin
      rem_next = shifted[WIDTH-1:0];
      q_next   = {q[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_32bit_seq.sv
// Multi-cycle restoring divider (DIV/DIVU). Operands are latched on
// accept, converted to magnitudes, iterated one bit per cycle and the
// signs are re-applied in FIX, where all outputs register.
module div_32bit_seq
  import div_pkg::*;
#(
  parameter int WIDTH = ITER_COUNT
) (
  input logic               clock,
  input logic               reset_n,
  div_32bit_seq_if.slave    bus
);

  localparam int CNT_W = $clog2(WIDTH);

  div_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] dividend_q, dividend_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic             signed_q, signed_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_q;

  // Two's complement negate when neg is set; most-negative wraps to itself.
  function automatic logic [WIDTH-1:0] negate_if(input logic [WIDTH-1:0] v,
                                                 input logic             neg);
    logic signed [WIDTH-1:0] sv;
    sv = $signed(v);
    return neg ? $unsigned(-sv) : v;
  endfunction

  // Magnitude of a two's complement value (most-negative stays as-is,
  // which is its correct unsigned magnitude).
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    return negate_if(v, v[WIDTH-1]);
  endfunction

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_q),
    .q        (q_q),
    .divisor  (divisor_q),
    .rem_next (step_rem),
    .q_next   (step_q)
  );

  // Next-state, datapath and output register logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dividend_d  = dividend_q;
    divisor_d   = divisor_q;
    signed_d    = signed_q;
    rem_d       = rem_q;
    q_d         = q_q;
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    busy_d      = busy_q;
    done_d      = done_q;

    case (state_q)
      IDLE, DONE: begin
        done_d = 1'b0;
        if (bus.start) begin
          state_d    = PREP;
          busy_d     = 1'b1;
          dividend_d = bus.dividend;
          divisor_d  = bus.divisor;
          signed_d   = bus.is_signed;
        end else begin
          state_d = IDLE;
        end
      end

      PREP: begin
        // dividend_q keeps the raw value for the divide-by-zero result;
        // the magnitude goes into the shifting quotient register.
        rem_d     = '0;
        q_d       = signed_q ? magnitude(dividend_q) : dividend_q;
        divisor_d = signed_q ? magnitude(divisor_q) : divisor_q;
        q_neg_d   = signed_q & (dividend_q[WIDTH-1] ^ divisor_q[WIDTH-1]);
        r_neg_d   = signed_q & dividend_q[WIDTH-1];
        cnt_d     = '0;
        state_d   = ITER;
      end

      ITER: begin
        rem_d = step_rem;
        q_d   = step_q;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = FIX;
        end
      end

      FIX: begin
        // A zero magnitude divisor means the original divisor was zero.
        if (divisor_q == '0) begin
          quotient_d  = WIDTH'(DIV0_QUOTIENT);
          remainder_d = dividend_q;
          dbz_d       = 1'b1;
        end else begin
          quotient_d  = negate_if(q_q, q_neg_q);
          remainder_d = negate_if(rem_q, r_neg_q);
          dbz_d       = 1'b0;
        end
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = DONE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and result registers; reset aborts any operation in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      dividend_q  <= '0;
      divisor_q   <= '0;
      signed_q    <= 1'b0;
      rem_q       <= '0;
      q_q         <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dividend_q  <= dividend_d;
      divisor_q   <= divisor_d;
      signed_q    <= signed_d;
      rem_q       <= rem_d;
      q_q         <= q_d;
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_32bit_seq.sv
// Bench for div_32bit_seq: vector table plus hand-written corner sequences,
// with results checked by a scoreboard whenever done is seen.
module tb_div_32bit_seq;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  always #5 clock = ~clock;

  div_32bit_seq_if #(.WIDTH(32)) bus ();

  div_32bit_seq #(.WIDTH(32)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
  } vec_t;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
  } res_t;

  res_t sb[$];
  vec_t vecs[10];
  int   errors = 0;
  int   checks = 0;
  int   dones  = 0;
  logic prev_done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: compare every done cycle against the oldest expectation.
  always @(negedge clock) begin : monitor
    res_t e;
    if (reset_n && bus.done === 1'b1) begin
      dones++;
      chk("done_one_cycle", {31'b0, prev_done}, 32'd0);
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("quotient", bus.quotient, e.q);
        chk("remainder", bus.remainder, e.r);
        chk("div_by_zero", {31'b0, bus.div_by_zero}, {31'b0, e.dbz});
      end
    end
    prev_done = reset_n ? bus.done : 1'b0;
  end

  // Drive a request once the divider is free; optionally record the expectation.
  task automatic accept(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input bit push, input logic [31:0] eq, input logic [31:0] er,
                        input logic edbz);
    int n;
    n = 0;
    while (bus.busy !== 1'b0 && n < 100) begin
      @(posedge clock);
      #1;
      n++;
    end
    chk("idle_before_accept", {31'b0, bus.busy}, 32'd0);
    bus.is_signed = sgn;
    bus.dividend  = a;
    bus.divisor   = b;
    bus.start     = 1'b1;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    if (push) sb.push_back('{q: eq, r: er, dbz: edbz});
    chk("busy_after_accept", {31'b0, bus.busy}, 32'd1);
  endtask

  // Count edges until done, checking busy stays high and the latency.
  task automatic wait_done(input int exp_n, input string tag);
    int n;
    bit busy_ok;
    n = 0;
    busy_ok = 1'b1;
    while (n < 60) begin
      @(posedge clock);
      #1;
      n++;
      if (bus.done === 1'b1) break;
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
    end
    chk({tag, "_latency"}, n, exp_n);
    chk({tag, "_busy_held"}, {31'b0, busy_ok}, 32'd1);
    chk({tag, "_busy_low_at_done"}, {31'b0, bus.busy}, 32'd0);
  endtask

  initial begin
    int d0;
    vecs[0] = '{1'b0, 32'd100,        32'd7,        32'd14,        32'd2,        1'b0};
    vecs[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,        32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0};
    vecs[2] = '{1'b0, 32'hFFFF_FFF9,  32'd2,        32'h7FFF_FFFC, 32'd1,        1'b0};
    vecs[3] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 32'd0,       1'b0};
    vecs[4] = '{1'b1, 32'd5,          32'd0,        32'hFFFF_FFFF, 32'd5,        1'b1};
    vecs[5] = '{1'b0, 32'd5,          32'd0,        32'hFFFF_FFFF, 32'd5,        1'b1};
    vecs[6] = '{1'b1, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,       1'b0};
    vecs[7] = '{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9, 32'd14,       32'hFFFF_FFFE, 1'b0};
    vecs[8] = '{1'b0, 32'hFFFF_FFFF,  32'd1,        32'hFFFF_FFFF, 32'd0,        1'b0};
    vecs[9] = '{1'b1, 32'hFFFF_FFFB,  32'd0,        32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1};

    bus.start     = 1'b0;
    bus.is_signed = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;

    // Reset state.
    #1;
    chk("rst_busy", {31'b0, bus.busy}, 32'd0);
    chk("rst_done", {31'b0, bus.done}, 32'd0);
    chk("rst_quotient", bus.quotient, 32'd0);
    chk("rst_remainder", bus.remainder, 32'd0);
    chk("rst_dbz", {31'b0, bus.div_by_zero}, 32'd0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;

    // Vector table.
    for (int i = 0; i < 10; i++) begin
      accept(vecs[i].sgn, vecs[i].a, vecs[i].b, 1'b1, vecs[i].q, vecs[i].r, vecs[i].dbz);
      wait_done(34, $sformatf("vec%0d", i));
      @(posedge clock);
      #1;
      chk($sformatf("vec%0d_done_drop", i), {31'b0, bus.done}, 32'd0);
    end

    // Reset during iteration 10 aborts with no done.
    accept(1'b0, 32'd100, 32'd7, 1'b0, 32'd0, 32'd0, 1'b0);
    repeat (11) @(posedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    chk("abort_busy", {31'b0, bus.busy}, 32'd0);
    chk("abort_done", {31'b0, bus.done}, 32'd0);
    chk("abort_quotient", bus.quotient, 32'd0);
    chk("abort_remainder", bus.remainder, 32'd0);
    chk("abort_dbz", {31'b0, bus.div_by_zero}, 32'd0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    d0 = dones;
    repeat (40) @(posedge clock);
    #1;
    chk("abort_no_done", dones - d0, 32'd0);
    accept(1'b0, 32'd9, 32'd3, 1'b1, 32'd3, 32'd0, 1'b0);
    wait_done(34, "after_abort");
    @(posedge clock);
    #1;

    // start while busy and operand changes after accept are ignored.
    accept(1'b0, 32'd1000, 32'd10, 1'b1, 32'd100, 32'd0, 1'b0);
    repeat (4) @(posedge clock);
    #1;
    bus.start     = 1'b1;
    bus.is_signed = 1'b1;
    bus.dividend  = 32'd77;
    bus.divisor   = 32'd3;
    @(posedge clock);
    #1;
    bus.start    = 1'b0;
    bus.dividend = $urandom;
    bus.divisor  = 32'd0;
    wait_done(29, "ignore_busy");
    @(posedge clock);
    #1;
    chk("ignore_done_drop", {31'b0, bus.done}, 32'd0);
    chk("ignore_stay_idle", {31'b0, bus.busy}, 32'd0);
    @(posedge clock);
    #1;
    chk("ignore_still_idle", {31'b0, bus.busy}, 32'd0);

    // Back-to-back: second start issued in the DONE cycle.
    accept(1'b0, 32'd200, 32'd9, 1'b1, 32'd22, 32'd2, 1'b0);
    wait_done(34, "b2b_first");
    accept(1'b0, 32'd50, 32'd6, 1'b1, 32'd8, 32'd2, 1'b0);
    chk("b2b_done_drop", {31'b0, bus.done}, 32'd0);
    wait_done(34, "b2b_second");

    repeat (3) @(posedge clock);
    #1;
    chk("scoreboard_drained", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
